// File: rtl/pim_pkg.sv
// Shared PIM definitions: ALU op encodings, sequencer state encoding and a
// reference ALU function for the 32-bit datapath.
package pim_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int unsigned PIM_DW = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        CAP_B = 3'd3,
        EXEC  = 3'd4,
        WB    = 3'd5
    } seq_state_e;

    // Combinational PIM ALU behaviour; carry and borrow are dropped.
    function automatic logic [PIM_DW-1:0] pim_alu(input logic [1:0]        op,
                                                  input logic [PIM_DW-1:0] a,
                                                  input logic [PIM_DW-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            default: return a | b;
        endcase
    endfunction

endpackage

// File: rtl/pim_op_sequencer.sv
// Single-command PIM op sequencer: read A, read B, execute on the external ALU,
// write the result back. One command in flight, six cycles per command.
module pim_op_sequencer
    import pim_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_src_a,
    input  logic [ADDR_WIDTH-1:0] cmd_src_b,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [1:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  done,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  op_count
);

    seq_state_e r_state;
    seq_state_e w_state_next;

    logic [1:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_src_a;
    logic [ADDR_WIDTH-1:0] r_src_b;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [DATA_WIDTH-1:0] r_opa;
    logic [DATA_WIDTH-1:0] r_opb;
    logic [DATA_WIDTH-1:0] r_res;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic [1:0]            r_alu_op;
    logic [CNT_WIDTH-1:0]  r_op_count;

    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_alu_a;
    logic [DATA_WIDTH-1:0] w_alu_b;
    logic [1:0]            w_alu_op;

    assign w_accept = cmd_valid && (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    w_state_next = w_accept ? RD_A : IDLE;
            RD_A:    w_state_next = RD_B;
            RD_B:    w_state_next = CAP_B;
            CAP_B:   w_state_next = EXEC;
            EXEC:    w_state_next = WB;
            WB:      w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Address and ALU inputs are driven in their own states and hold otherwise.
    always_comb begin
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        mem_we     = 1'b0;
        done       = 1'b0;
        w_mem_addr = r_mem_addr;
        w_alu_a    = r_alu_a;
        w_alu_b    = r_alu_b;
        w_alu_op   = r_alu_op;
        unique case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            RD_A:  w_mem_addr = r_src_a;
            RD_B:  w_mem_addr = r_src_b;
            CAP_B: ;
            EXEC: begin
                w_alu_a  = r_opa;
                w_alu_b  = r_opb;
                w_alu_op = r_op;
            end
            WB: begin
                w_mem_addr = r_dst;
                mem_we     = 1'b1;
                done       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= '0;
            r_src_a    <= '0;
            r_src_b    <= '0;
            r_dst      <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_res      <= '0;
            r_mem_addr <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_op_count <= '0;
        end else begin
            r_mem_addr <= w_mem_addr;
            r_alu_a    <= w_alu_a;
            r_alu_b    <= w_alu_b;
            r_alu_op   <= w_alu_op;
            if (w_accept) begin
                r_op    <= cmd_op;
                r_src_a <= cmd_src_a;
                r_src_b <= cmd_src_b;
                r_dst   <= cmd_dst;
            end
            if (r_state == RD_B) begin
                r_opa <= mem_rdata;
            end
            if (r_state == CAP_B) begin
                r_opb <= mem_rdata;
            end
            if (r_state == EXEC) begin
                r_res <= alu_result;
            end
            if (r_state == WB) begin
                r_op_count <= r_op_count + CNT_WIDTH'(1);
            end
        end
    end

    assign mem_addr  = w_mem_addr;
    assign mem_wdata = r_res;
    assign alu_a     = w_alu_a;
    assign alu_b     = w_alu_b;
    assign alu_op    = w_alu_op;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_pim_op_sequencer.sv
// Bench for pim_op_sequencer: sync-read memory model plus ALU model, a write
// scoreboard and a narrow-counter instance for the wrap check.
module tb_pim_op_sequencer;
    import pim_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_src_a = '0;
    logic [AW-1:0] cmd_src_b = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [1:0]    alu_op;
    logic [DW-1:0] alu_result;
    logic          done;
    logic          busy;
    logic [CW-1:0] op_count;

    // Narrow-counter instance, only its count and done are observed.
    logic          n_valid = 1'b0;
    logic          n_ready;
    logic [AW-1:0] n_mem_addr;
    logic          n_mem_we;
    logic [DW-1:0] n_mem_wdata;
    logic [DW-1:0] n_alu_a;
    logic [DW-1:0] n_alu_b;
    logic [1:0]    n_alu_op;
    logic          n_done;
    logic          n_busy;
    logic [2:0]    n_count;

    always #5 clk = ~clk;

    pim_op_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .alu_a(alu_a),
        .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .done(done), .busy(busy),
        .op_count(op_count)
    );

    pim_op_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(3)) dut_n (
        .clk(clk), .rst(rst), .cmd_valid(n_valid), .cmd_ready(n_ready), .cmd_op(OP_ADD),
        .cmd_src_a(8'd0), .cmd_src_b(8'd0), .cmd_dst(8'd0), .mem_addr(n_mem_addr),
        .mem_we(n_mem_we), .mem_wdata(n_mem_wdata), .mem_rdata(32'd0), .alu_a(n_alu_a),
        .alu_b(n_alu_b), .alu_op(n_alu_op), .alu_result(32'd0), .done(n_done), .busy(n_busy),
        .op_count(n_count)
    );

    logic [DW-1:0] mem [256];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    assign alu_result = pim_alu(alu_op, alu_a, alu_b);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    wr_t sb[$];
    int  errors = 0;
    int  checks = 0;
    int  done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the oldest expected write, address, data and cycle.
    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (done) done_cnt++;
            if (mem_we) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                             mem_addr, mem_wdata);
                end else begin
                    e = sb.pop_front();
                    check("wb_addr", 64'(mem_addr), 64'(e.addr));
                    check("wb_data", 64'(mem_wdata), 64'(e.data));
                    check("wb_cycle", 64'(cyc), 64'(e.cyc));
                    check("wb_done", 64'(done), 64'd1);
                end
            end else if (done) begin
                check("done_without_we", 64'(mem_we), 64'd1);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] d, input logic [DW-1:0] exp, input bit push,
                         input bit hold, output int ta);
        int n;
        @(negedge clk);
        cmd_op    = op;
        cmd_src_a = a;
        cmd_src_b = b;
        cmd_dst   = d;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 64'(cmd_ready), 64'd1);
        ta = cyc + 1;
        if (push) sb.push_back('{addr: d, data: exp, cyc: ta + 4});
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !cmd_ready) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("idle_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int ta;
        int ta2;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[1] = 32'd5;
        mem[2] = 32'd7;
        mem[4] = 32'd3;
        mem[5] = 32'd10;
        mem[7] = 32'hF0F0_F0F0;
        mem[8] = 32'hFF00_FF00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_b", 64'(alu_b), 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        rst = 1'b0;

        // 1: add
        issue(OP_ADD, 8'd1, 8'd2, 8'd3, 32'd12, 1'b1, 1'b0, ta);
        wait_idle();
        check("t1_mem3", 64'(mem[3]), 64'd12);
        check("t1_done_pulses", 64'(done_cnt), 64'd1);
        check("t1_op_count", 64'(op_count), 64'd1);

        // 2: sub with wrap, ready low through the whole command
        issue(OP_SUB, 8'd4, 8'd5, 8'd6, 32'hFFFF_FFF9, 1'b1, 1'b0, ta);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_ready_low", 64'(cmd_ready), 64'd0);
            check("t2_busy_high", 64'(busy), 64'd1);
        end
        @(negedge clk);
        check("t2_ready_back", 64'(cmd_ready), 64'd1);
        wait_idle();
        check("t2_mem6", 64'(mem[6]), 64'hFFFF_FFF9);

        // 3: back-to-back and/or with dst aliasing src_a
        do_reset();
        issue(OP_AND, 8'd7, 8'd8, 8'd7, 32'hF000_F000, 1'b1, 1'b0, ta);
        issue(OP_OR, 8'd7, 8'd8, 8'd9, 32'hFF00_FF00, 1'b1, 1'b0, ta2);
        check("t3_second_accept", 64'(ta2 - ta), 64'd6);
        wait_idle();
        check("t3_mem7", 64'(mem[7]), 64'hF000_F000);
        check("t3_mem9", 64'(mem[9]), 64'hFF00_FF00);
        check("t3_op_count", 64'(op_count), 64'd2);

        // 4: valid held with changing fields while busy
        do_reset();
        issue(OP_ADD, 8'd1, 8'd2, 8'd10, 32'd12, 1'b1, 1'b1, ta);
        n = 0;
        while (cmd_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (cyc == ta + 4) begin
                cmd_valid = 1'b0;
            end else begin
                cmd_op    = OP_SUB;
                cmd_src_a = 8'd4;
                cmd_src_b = 8'd5;
                cmd_dst   = 8'(20 + n);
            end
        end
        cmd_valid = 1'b0;
        wait_idle();
        repeat (8) @(negedge clk);
        check("t4_mem10", 64'(mem[10]), 64'd12);
        for (int i = 20; i < 26; i++) check("t4_no_stray", 64'(mem[i]), 64'd0);
        check("t4_op_count", 64'(op_count), 64'd1);

        // 5: reset during EXEC
        issue(OP_ADD, 8'd1, 8'd2, 8'd30, 32'd12, 1'b0, 1'b0, ta);
        n = 0;
        while (cyc != ta + 3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_busy_exec", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_mem_we", 64'(mem_we), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        check("t5_op_count", 64'(op_count), 64'd0);
        check("t5_cmd_ready", 64'(cmd_ready), 64'd1);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_mem30", 64'(mem[30]), 64'd0);
        check("t5_op_count_after", 64'(op_count), 64'd0);

        // 6: counter wrap on a 3-bit counter instance
        do_reset();
        n_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            n = 0;
            @(negedge clk);
            while (!n_done && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("t6_done_seen", 64'(n_done), 64'd1);
            @(negedge clk);
            check("t6_count", 64'(n_count), 64'(k % 8));
        end
        n_valid = 1'b0;
        repeat (8) @(negedge clk);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
